sequence_player: RTL
====================

# sequence_player

Downstream consumer of the pattern generator: once the generator has filled the 32-entry sequence RAM and pulsed its finish flag, this block reads the first `len` entries back through the RAM's second port. It presents each 4-bit entry on `led` for a programmable on-time, then blanks for an off-time, and pulses `done` after the last step. It drives the game's display/LED path and is the block the round controller starts each level.

## Interface
Parameters:
- `DEPTH`, 32: sequence entries; address width is `ADDR_W = $clog2(DEPTH)` = 5.
- `DATA_W`, 4: entry width.
- `ON_CYCLES`, 4: cycles each entry is shown; must be ≥1.
- `OFF_CYCLES`, 2: blank cycles after each entry; must be ≥1.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `seq_ready`  in  1  one-cycle pulse from the generator's finish; sets the internal `loaded` flag.
- `start`  in  1  level-sampled request to play.
- `abort`  in  1  synchronous abort of playback.
- `len`  in  6  number of steps to play; valid range 1..32.
- `rd_addr`  out  5  RAM read address.
- `rd_data`  in  4  RAM read data; synchronous read, valid one cycle after `rd_addr`.
- `led`  out  4  current entry; 0 when not showing.
- `led_valid`  out  1  high while `led` carries an entry.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when playback completes normally.
- `step`  out  5  index of the entry being played.

## Operation
- States: IDLE, FETCH, LATCH, SHOW, GAP.
- **IDLE**
  - `loaded` is set by `seq_ready` and cleared only by `rst`.
  - If `start && loaded` is sampled, capture `len_q`: `len` values above 32 clamp to 32.
  - If `len == 0`: stay in IDLE and pulse `done` next cycle.
  - Otherwise: `step <= 0`, `rd_addr <= 0`, go to FETCH.
  - `start` with `!loaded` is ignored.
- **FETCH**: one cycle, waits out the RAM read latency. Go to LATCH.
- **LATCH**: `led <= rd_data`, `led_valid <= 1`, load timer with `ON_CYCLES-1`. Go to SHOW.
- **SHOW**: timer decrements. At 0: `led <= 0`, `led_valid <= 0`, load timer with `OFF_CYCLES-1`, go to GAP.
- **GAP**: timer decrements. At 0:
  - If `step == len_q-1`: go to IDLE and pulse `done`.
  - Otherwise: `step <= step+1`, `rd_addr <= step+1`, go to FETCH.
- **`abort`**: in any non-IDLE state, next edge goes to IDLE, `led <= 0`, `led_valid <= 0`, no `done`. `abort` takes priority over every other transition.
- `start` while busy is ignored; `len` changes while busy are ignored because `len_q` is frozen.
- `seq_ready` during playback only re-sets `loaded`; the current playback continues.
- Reset values: `led`=0, `led_valid`=0, `busy`=0, `done`=0, `step`=0, `rd_addr`=0, `loaded`=0, state=IDLE.
- Width rules:
  - `step` is 5 bits, so index 31 is reachable with `len_q` = 32.
  - Compare against `len_q-1` in 6 bits, so there is no wrap.

## Timing
- Start sampled at edge E0 → FETCH. `led_valid` rises at E2, so the first entry is visible 2 cycles after `start`.
- Per-step period is `ON_CYCLES + OFF_CYCLES + 2` cycles.
  - `led_valid` high for exactly `ON_CYCLES` cycles.
  - Low for `OFF_CYCLES + 2` cycles between entries.
- `done` is asserted in the cycle after the last GAP cycle. `busy` is already low in that cycle.
- Total: `done` at E0 + `len_q·(ON+OFF+2)`.
- `rd_addr` is registered and changes only on FETCH entry.
- Asynchronous `rst` mid-playback clears all outputs immediately, without waiting for a clock edge.

## Structure
- Package `orion_pkg`:
  - `player_state_t` enum: IDLE, FETCH, LATCH, SHOW, GAP.
  - `SEQ_DEPTH` = 32, `SEQ_DATA_W` = 4, `SEQ_ADDR_W` = 5. These are shared with the generator.
- Sub-module `phase_timer`:
  - Loadable down-counter with width `$clog2(max(ON,OFF))+1`.
  - Signals: `load`, `load_val`, `zero`.
- The top holds the FSM, `len_q`, `step`, `loaded` and the output registers.

## Test plan
- **Normal playback.** RAM = {0x3,0xA,0x5,…}, `ON`=3, `OFF`=2, `seq_ready` pulse, `len`=3, `start` → `led` sequence 3,3,3,0×4,A,A,A,0×4,5,5,5,0×2. `done` is pulsed exactly 21 cycles after start.
- **Not loaded.** `start` with no prior `seq_ready` → `busy` stays 0, `led_valid` stays 0, no `done`.
- **Full length and clamp.** `len`=32, then `len`=40 → 32 steps each; `rd_addr` runs 0..31; `step` ends at 31 without wrap.
- **Empty request.** `len`=0 with `loaded` set → no `led_valid`; `done` one cycle after start; `busy` stays 0.
- **Abort.** Assert `abort` during step 1 SHOW → next cycle `led`=0, `busy`=0, no `done`. A following `start` plays from step 0.
- **Async reset.** Assert `rst` between clock edges mid-GAP → all outputs 0 immediately. `loaded` is cleared, so a later `start` is ignored until a new `seq_ready` arrives.

Source files
------------

// File: rtl/orion_pkg.sv
// Shared definitions for the sequence generator / player pair.
// Sizes here must stay in step with the sequence RAM the generator fills.
package orion_pkg;

   localparam int SEQ_DEPTH  = 32;
   localparam int SEQ_DATA_W = 4;
   localparam int SEQ_ADDR_W = $clog2(SEQ_DEPTH);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      LATCH,
      SHOW,
      GAP
   } player_state_t;

   function automatic int max_of(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter that times the on and off phases of each step.
// It parks at zero until the next load.
module phase_timer #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         zero
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (count_q != '0) begin
         count_d = count_q - W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign zero = (count_q == '0);

endmodule

// File: rtl/sequence_player.sv
// Plays back the first len entries of the sequence RAM on the LED path,
// each shown for ON_CYCLES and followed by a blank, then pulses done.
module sequence_player
   import orion_pkg::*;
#(
   parameter  int DEPTH      = SEQ_DEPTH,
   parameter  int DATA_W     = SEQ_DATA_W,
   parameter  int ON_CYCLES  = 4,
   parameter  int OFF_CYCLES = 2,
   localparam int ADDR_W     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              seq_ready,
   input  logic              start,
   input  logic              abort,
   input  logic [5:0]        len,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   output logic [DATA_W-1:0] led,
   output logic              led_valid,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] step
);

   localparam int TIMER_W = $clog2(max_of(ON_CYCLES, OFF_CYCLES)) + 1;
   localparam logic [TIMER_W-1:0] ON_LOAD  = TIMER_W'(ON_CYCLES - 1);
   localparam logic [TIMER_W-1:0] OFF_LOAD = TIMER_W'(OFF_CYCLES - 1);
   localparam logic [5:0]         MAX_LEN  = 6'(DEPTH);

   player_state_t     state_q, state_d;
   logic [5:0]        len_q, len_d;
   logic [ADDR_W-1:0] step_q, step_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic              loaded_q, loaded_d;
   logic [DATA_W-1:0] led_q, led_d;
   logic              led_valid_q, led_valid_d;
   logic              done_q, done_d;
   logic              busy_q, busy_d;

   logic               timer_load;
   logic [TIMER_W-1:0] timer_val;
   logic               timer_zero;

   phase_timer #(
      .W (TIMER_W)
   ) u_phase_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (timer_load),
      .load_val (timer_val),
      .zero     (timer_zero)
   );

   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      step_d      = step_q;
      rd_addr_d   = rd_addr_q;
      loaded_d    = loaded_q | seq_ready;
      led_d       = led_q;
      led_valid_d = led_valid_q;
      done_d      = 1'b0;
      timer_load  = 1'b0;
      timer_val   = ON_LOAD;

      if (abort && state_q != IDLE) begin
         state_d     = IDLE;
         led_d       = '0;
         led_valid_d = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start && loaded_q) begin
                  len_d = (len > MAX_LEN) ? MAX_LEN : len;
                  if (len == 6'd0) begin
                     done_d = 1'b1;
                  end else begin
                     step_d    = '0;
                     rd_addr_d = '0;
                     state_d   = FETCH;
                  end
               end
            end
            FETCH: begin
               state_d = LATCH;
            end
            LATCH: begin
               led_d       = rd_data;
               led_valid_d = 1'b1;
               timer_load  = 1'b1;
               timer_val   = ON_LOAD;
               state_d     = SHOW;
            end
            SHOW: begin
               if (timer_zero) begin
                  led_d       = '0;
                  led_valid_d = 1'b0;
                  timer_load  = 1'b1;
                  timer_val   = OFF_LOAD;
                  state_d     = GAP;
               end
            end
            GAP: begin
               // Compare in the 6-bit length domain so len_q = 32 ends at step 31.
               if (timer_zero) begin
                  if (6'(step_q) == len_q - 6'd1) begin
                     state_d = IDLE;
                     done_d  = 1'b1;
                  end else begin
                     step_d    = step_q + ADDR_W'(1);
                     rd_addr_d = step_q + ADDR_W'(1);
                     state_d   = FETCH;
                  end
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         len_q       <= '0;
         step_q      <= '0;
         rd_addr_q   <= '0;
         loaded_q    <= 1'b0;
         led_q       <= '0;
         led_valid_q <= 1'b0;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         step_q      <= step_d;
         rd_addr_q   <= rd_addr_d;
         loaded_q    <= loaded_d;
         led_q       <= led_d;
         led_valid_q <= led_valid_d;
         done_q      <= done_d;
         busy_q      <= busy_d;
      end
   end

   assign rd_addr   = rd_addr_q;
   assign led       = led_q;
   assign led_valid = led_valid_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign step      = step_q;

endmodule
